// File: rtl/u_xmit_arb.sv
// Round-robin arbiter/sequencer sharing one u_xmit transmitter between NUM_REQ byte sources.
// Grants one byte per frame, strobes xmitH, then tracks xmit_doneH with ack/frame timeouts.
module u_xmit_arb #(
  parameter int NUM_REQ  = 4,
  parameter int ACK_TO   = 8,
  parameter int FRAME_TO = 1023,
  parameter int TO_W     = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 xmitH,
  output logic [7:0]           xmit_dataH,
  input  logic                 xmit_doneH,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 timeout_err,
  input  logic                 err_clr
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH} state_t;

  state_t          state_q, state_d;
  logic [2:0]      rrPtr_q, rrPtr_d;
  logic [TO_W-1:0] cnt_q, cnt_d, cntInc;
  logic [7:0]      data_q, data_d;
  logic [2:0]      grant_q, grant_d;
  logic            xmit_q, xmit_d;
  logic            frameDone_q, frameDone_d;
  logic            err_q, err_d;
  logic            errSet;

  logic            grantValid;
  logic [2:0]      grantIdx;
  logic [2:0]      ptrNext;
  logic [7:0]      grantByte;
  logic            doGrant;

  // First valid requester at or after rrPtr_q, wrapping; distance k gives priority.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!grantValid && req_valid[j] && ((int'(rrPtr_q) + k) % NUM_REQ == j)) begin
          grantValid = 1'b1;
          grantIdx   = 3'(j);
        end
      end
    end
  end

  always_comb begin
    grantByte = '0;
    req_ready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grantIdx == 3'(j)) grantByte = req_data[8*j +: 8];
      req_ready[j] = doGrant && (grantIdx == 3'(j));
    end
  end

  assign doGrant = (state_q == IDLE) && xmit_doneH && grantValid;
  assign ptrNext = (int'(grantIdx) + 1 == NUM_REQ) ? 3'd0 : grantIdx + 3'd1;
  assign cntInc  = cnt_q + TO_W'(1);

  always_comb begin
    state_d     = state_q;
    rrPtr_d     = rrPtr_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    grant_d     = grant_q;
    frameDone_d = 1'b0;
    errSet      = 1'b0;
    case (state_q)
      IDLE: begin
        if (doGrant) begin
          data_d  = grantByte;
          grant_d = grantIdx;
          rrPtr_d = ptrNext;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!xmit_doneH) begin
          cnt_d   = '0;
          state_d = WAIT_HIGH;
        end else if (cntInc == TO_W'(ACK_TO)) begin
          errSet  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cntInc;
        end
      end
      WAIT_HIGH: begin
        if (xmit_doneH) begin
          frameDone_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else if (cntInc == TO_W'(FRAME_TO)) begin
          errSet  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cntInc;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new timeout takes priority over a simultaneous clear.
    err_d  = errSet ? 1'b1 : (err_clr ? 1'b0 : err_q);
    xmit_d = (state_d == ISSUE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      rrPtr_q     <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      grant_q     <= '0;
      xmit_q      <= 1'b0;
      frameDone_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rrPtr_q     <= rrPtr_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      grant_q     <= grant_d;
      xmit_q      <= xmit_d;
      frameDone_q <= frameDone_d;
      err_q       <= err_d;
    end
  end

  assign xmitH       = xmit_q;
  assign xmit_dataH  = data_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != IDLE);
  assign frame_done  = frameDone_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_u_xmit_arb.sv
// Directed bench for u_xmit_arb with a small behavioural u_xmit done-line model.
module tb_u_xmit_arb;
  localparam int NUM_REQ  = 4;
  localparam int ACK_TO   = 8;
  localparam int FRAME_TO = 1023;
  localparam int TO_W     = 16;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 xmitH;
  logic [7:0]           xmit_dataH;
  logic                 xmit_doneH;
  logic [2:0]           grant_id;
  logic                 busy;
  logic                 frame_done;
  logic                 timeout_err;
  logic                 err_clr;

  int total = 0;
  int bad   = 0;

  // 0: silent (done stays as is), 1: normal frame, 2: drop done and never raise it
  int modelMode = 1;
  int lowDly    = 2;
  int highDly   = 170;

  u_xmit_arb #(.NUM_REQ(NUM_REQ), .ACK_TO(ACK_TO), .FRAME_TO(FRAME_TO), .TO_W(TO_W)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .xmitH      (xmitH),
    .xmit_dataH (xmit_dataH),
    .xmit_doneH (xmit_doneH),
    .grant_id   (grant_id),
    .busy       (busy),
    .frame_done (frame_done),
    .timeout_err(timeout_err),
    .err_clr    (err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  // Transmitter model: reacts to the start strobe on the falling edge.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (xmitH === 1'b1 && modelMode != 0) begin
        repeat (lowDly) @(negedge sys_clk);
        xmit_doneH = 1'b0;
        if (modelMode == 1) begin
          repeat (highDly) @(negedge sys_clk);
          xmit_doneH = 1'b1;
        end
      end
    end
  end

  task automatic waitXmit(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge sys_clk); #1;
      if (xmitH === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitIdle(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge sys_clk); #1;
      if (busy === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic doReset();
    @(negedge sys_clk);
    sys_rst   = 1'b1;
    req_valid = '0;
    err_clr   = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] obs;
    sys_rst    = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    err_clr    = 1'b0;
    xmit_doneH = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    obs = {req_ready, xmitH, xmit_dataH, grant_id, busy, frame_done, timeout_err};
    total++;
    if (obs !== 21'h0) begin
      bad++;
      $display("[TB] FAIL reset_values: got %h want %h", obs, 21'h0);
    end
  endtask

  task automatic test_single_byte();
    int readyCnt, xmitCnt, doneCnt, dataBad;
    @(negedge sys_clk);
    req_data[7:0] = 8'hA5;
    req_valid     = 4'b0001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("[TB] FAIL t1_ready: got %b want 0001", req_ready);
    end
    readyCnt = 1; xmitCnt = 0; doneCnt = 0; dataBad = 0;
    @(posedge sys_clk); #1;
    req_valid = '0;
    total++;
    if (xmitH !== 1'b1) begin
      bad++;
      $display("[TB] FAIL t1_latency: xmitH got %b want 1", xmitH);
    end
    for (int i = 0; i < 260; i++) begin
      if (i > 0) begin
        @(posedge sys_clk); #1;
      end
      if (req_ready !== '0) readyCnt++;
      if (xmitH === 1'b1) xmitCnt++;
      if (frame_done === 1'b1) doneCnt++;
      if (busy === 1'b1 && xmit_dataH !== 8'hA5) dataBad++;
    end
    total++;
    if (readyCnt != 1) begin bad++; $display("[TB] FAIL t1_ready_count: got %0d want 1", readyCnt); end
    total++;
    if (xmitCnt != 1) begin bad++; $display("[TB] FAIL t1_xmit_count: got %0d want 1", xmitCnt); end
    total++;
    if (doneCnt != 1) begin bad++; $display("[TB] FAIL t1_done_count: got %0d want 1", doneCnt); end
    total++;
    if (dataBad != 0) begin bad++; $display("[TB] FAIL t1_data_hold: bad cycles %0d want 0", dataBad); end
    total++;
    if ({grant_id, xmit_dataH, busy, timeout_err} !== {3'd0, 8'hA5, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL t1_final: grant %0d data %h busy %b err %b want 0 a5 0 0",
               grant_id, xmit_dataH, busy, timeout_err);
    end
  endtask

  task automatic test_round_robin();
    bit seen;
    logic [2:0] expG;
    logic [7:0] expD;
    highDly = 5;
    doReset();
    @(negedge sys_clk);
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      waitXmit(seen);
      expG = 3'(k % 4);
      expD = 8'(8'h11 * (k % 4 + 1));
      if (k == 7) req_valid = '0;
      total++;
      if (!seen || grant_id !== expG) begin
        bad++;
        $display("[TB] FAIL t2_grant[%0d]: got %0d want %0d (strobe seen %b)", k, grant_id, expG, seen);
      end
      total++;
      if (xmit_dataH !== expD) begin
        bad++;
        $display("[TB] FAIL t2_data[%0d]: got %h want %h", k, xmit_dataH, expD);
      end
    end
    waitIdle(seen);
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL t2_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_wrap_skip();
    bit seen;
    @(negedge sys_clk);
    req_valid = 4'b0100;
    waitXmit(seen);
    req_valid = '0;
    total++;
    if (!seen || grant_id !== 3'd2 || xmit_dataH !== 8'h33) begin
      bad++;
      $display("[TB] FAIL t3_first: grant %0d data %h want 2 33", grant_id, xmit_dataH);
    end
    waitIdle(seen);
    @(negedge sys_clk);
    req_valid = 4'b0101;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("[TB] FAIL t3_wrap_ready: got %b want 0001", req_ready);
    end
    waitXmit(seen);
    total++;
    if (!seen || grant_id !== 3'd0) begin
      bad++;
      $display("[TB] FAIL t3_wrap_grant: got %0d want 0", grant_id);
    end
    waitXmit(seen);
    req_valid = '0;
    total++;
    if (!seen || grant_id !== 3'd2) begin
      bad++;
      $display("[TB] FAIL t3_skip_grant: got %0d want 2", grant_id);
    end
    waitIdle(seen);
  endtask

  task automatic test_withdraw();
    @(negedge sys_clk);
    modelMode  = 0;
    xmit_doneH = 1'b0;
    req_valid  = 4'b0010;
    #1;
    total++;
    if (req_ready !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL wd_done_low_ready: got %b want 0000", req_ready);
    end
    @(posedge sys_clk); #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL wd_no_grant: busy got %b want 0", busy); end
    @(negedge sys_clk);
    xmit_doneH = 1'b1;
    req_valid  = 4'b1111;
    #1;
    total++;
    if (req_ready !== 4'b1000) begin
      bad++;
      $display("[TB] FAIL wd_pointer: ready got %b want 1000", req_ready);
    end
    req_valid = '0;
    @(posedge sys_clk); #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL wd_withdrawn: busy got %b want 0", busy); end
  endtask

  task automatic test_ack_timeout();
    bit seen;
    @(negedge sys_clk);
    req_valid = 4'b0001;
    waitXmit(seen);
    req_valid = '0;
    err_clr   = 1'b1;
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL t4_strobe: xmitH got %b want 1", xmitH); end
    for (int i = 1; i <= ACK_TO; i++) begin
      @(posedge sys_clk); #1;
      total++;
      if ({timeout_err, busy} !== 2'b01) begin
        bad++;
        $display("[TB] FAIL t4_wait[%0d]: err,busy got %b want 01", i, {timeout_err, busy});
      end
    end
    @(posedge sys_clk); #1;
    total++;
    if ({timeout_err, busy} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL t4_timeout: err,busy got %b want 10", {timeout_err, busy});
    end
    @(posedge sys_clk); #1;
    total++;
    if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL t4_clear: err got %b want 0", timeout_err); end
    err_clr = 1'b0;
  endtask

  task automatic test_frame_timeout();
    bit seen;
    int idleAt;
    int doneSeen;
    @(negedge sys_clk);
    modelMode = 2;
    req_valid = 4'b0001;
    waitXmit(seen);
    req_valid = '0;
    idleAt    = -1;
    doneSeen  = 0;
    for (int j = 1; j < 1200; j++) begin
      @(posedge sys_clk); #1;
      if (frame_done === 1'b1) doneSeen++;
      if (busy === 1'b0) begin
        idleAt = j;
        break;
      end
    end
    total++;
    if (idleAt != 3 + FRAME_TO) begin
      bad++;
      $display("[TB] FAIL t5_duration: idle after %0d cycles want %0d", idleAt, 3 + FRAME_TO);
    end
    total++;
    if (timeout_err !== 1'b1) begin bad++; $display("[TB] FAIL t5_err: got %b want 1", timeout_err); end
    total++;
    if (doneSeen != 0) begin bad++; $display("[TB] FAIL t5_no_done: pulses %0d want 0", doneSeen); end
    @(negedge sys_clk);
    xmit_doneH = 1'b1;
    modelMode  = 1;
  endtask

  task automatic test_reset_mid_frame();
    bit seen;
    logic [20:0] obs;
    highDly = 50;
    @(negedge sys_clk);
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b0010;
    waitXmit(seen);
    req_valid = '0;
    total++;
    if (!seen || grant_id !== 3'd1) begin
      bad++;
      $display("[TB] FAIL t6_pre_grant: got %0d want 1", grant_id);
    end
    repeat (10) @(posedge sys_clk);
    #1;
    total++;
    if ({busy, xmit_doneH} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL t6_in_frame: busy,done got %b want 10", {busy, xmit_doneH});
    end
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    obs = {req_ready, xmitH, xmit_dataH, grant_id, busy, frame_done, timeout_err};
    total++;
    if (obs !== 21'h0) begin
      bad++;
      $display("[TB] FAIL t6_reset_values: got %h want %h", obs, 21'h0);
    end
    @(negedge sys_clk);
    sys_rst    = 1'b0;
    xmit_doneH = 1'b1;
    req_valid  = 4'b1111;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("[TB] FAIL t6_ready_after: got %b want 0001", req_ready);
    end
    waitXmit(seen);
    req_valid = '0;
    total++;
    if (!seen || grant_id !== 3'd0 || xmit_dataH !== 8'h11) begin
      bad++;
      $display("[TB] FAIL t6_grant_after: grant %0d data %h want 0 11", grant_id, xmit_dataH);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_round_robin();
    test_wrap_skip();
    test_withdraw();
    test_ack_timeout();
    test_frame_timeout();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
